// File: rtl/updi_arb_pkg.sv
// Shared types and helpers for the UPDI TX arbiter.
// Holds the FSM state encoding and the round-robin pointer step.
package updi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    LOAD,
    SEND
  } arb_state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/updi_tx_arbiter_rr_pick.sv
// Rotating-priority picker for the UPDI TX arbiter.
// Returns the first requester at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  // Scan from the highest offset down so the lowest offset from ptr wins
  always_comb begin
    int j;
    j      = 0;
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/updi_tx_arbiter.sv
// Frame-atomic round-robin arbiter draining source FIFOs into UPDI TX.
// Owner is held until its EOF byte; stalled frames abort after TIMEOUT.
module updi_tx_arbiter
  import updi_arb_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC-1:0]              src_empty,
  output logic [N_SRC-1:0]              src_rd_en,
  input  logic [N_SRC*(DATA_W+1)-1:0]   src_data,
  output logic [DATA_W-1:0]             tx_data,
  output logic                          tx_last,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [N_SRC-1:0]              grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic [N_SRC-1:0]  grant_q, grant_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     stall_q, stall_d;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic              txl_q, txl_d;
  logic              txv_q, txv_d;
  logic              terr_q, terr_d;

  logic [N_SRC-1:0]  req;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [N_SRC-1:0]  pick_oh;
  logic [DATA_W:0]   word [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_word
    assign word[i] = src_data[i*(DATA_W+1) +: DATA_W+1];
  end

  assign req = ~src_empty;

  rr_pick #(
    .N(N_SRC)
  ) u_pick (
    .req   (req),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx),
    .onehot(pick_oh)
  );

  // Next-state, pop strobe and TX register updates
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    stall_d   = stall_q;
    txd_d     = txd_q;
    txl_d     = txl_q;
    txv_d     = txv_q;
    terr_d    = 1'b0;
    src_rd_en = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          stall_d = '0;
          state_d = POP;
        end
      end
      POP: begin
        if (!src_empty[gidx_q]) begin
          src_rd_en = grant_q;
          stall_d   = '0;
          state_d   = LOAD;
        end else if (stall_q == CW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          grant_d = '0;
          rr_d    = IW'(rr_next(int'(gidx_q), N_SRC));
          state_d = IDLE;
        end else begin
          stall_d = stall_q + CW'(1);
        end
      end
      LOAD: begin
        txd_d   = word[gidx_q][DATA_W-1:0];
        txl_d   = word[gidx_q][DATA_W];
        txv_d   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          txv_d = 1'b0;
          if (txl_q) begin
            grant_d = '0;
            rr_d    = IW'(rr_next(int'(gidx_q), N_SRC));
            state_d = IDLE;
          end else begin
            state_d = POP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      stall_q <= '0;
      txd_q   <= '0;
      txl_q   <= 1'b0;
      txv_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
      txd_q   <= txd_d;
      txl_q   <= txl_d;
      txv_q   <= txv_d;
      terr_q  <= terr_d;
    end
  end

  assign tx_data     = txd_q;
  assign tx_last     = txl_q;
  assign tx_valid    = txv_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_updi_tx_arbiter.sv
// Scoreboard bench for updi_tx_arbiter with behavioural source FIFOs.
// Expected bytes are queued at stimulus time and popped on each handshake.
module tb_updi_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  src_empty = 2'b11;
  logic [1:0]  src_rd_en;
  logic [17:0] src_data;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  updi_tx_arbiter #(
    .N_SRC  (2),
    .DATA_W (8),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_empty  (src_empty),
    .src_rd_en  (src_rd_en),
    .src_data   (src_data),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] dout0 = '0;
  logic [8:0] dout1 = '0;
  logic [1:0] push_v = '0;
  logic [8:0] push_d0 = '0;
  logic [8:0] push_d1 = '0;

  assign src_data = {dout1, dout0};

  // Source FIFOs with one-cycle registered read
  always @(posedge clk) begin
    if (src_rd_en[0] && q0.size() > 0) dout0 <= q0.pop_front();
    if (src_rd_en[1] && q1.size() > 0) dout1 <= q1.pop_front();
    if (push_v[0]) q0.push_back(push_d0);
    if (push_v[1]) q1.push_back(push_d1);
    src_empty <= {q1.size() == 0, q0.size() == 0};
  end

  typedef struct packed {
    logic [1:0] g;
    logic       l;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tcount = 0;
  int   ncyc = 0;
  int   last_hs = 0;
  int   tgap = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every accepted TX byte against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      if (timeout_err) begin
        tcount++;
        tgap = ncyc - last_hs;
      end
      if (tx_valid && tx_ready) begin
        last_hs = ncyc;
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("tx_data", {24'h0, tx_data}, {24'h0, e.d});
          chk("tx_last", {31'h0, tx_last}, {31'h0, e.l});
          chk("grant", {30'h0, grant}, {30'h0, e.g});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [1:0] v, input logic [8:0] d0,
                      input logic [8:0] d1);
    push_v  = v;
    push_d0 = d0;
    push_d1 = d1;
    cyc();
    push_v = '0;
  endtask

  task automatic expect_b(input logic [1:0] g, input logic [8:0] w);
    exp_t e;
    e.g = g;
    e.l = w[8];
    e.d = w[7:0];
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      cyc();
      n++;
    end
    chk(nm, {31'h0, n < 300}, 1);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!tx_valid && n < 30) begin
      cyc();
      n++;
    end
    chk(nm, {31'h0, tx_valid}, 1);
  endtask

  initial begin
    int         n;
    int         bad;
    logic [7:0] hd;
    logic       hl;
    logic [1:0] hg;

    repeat (2) cyc();
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_grant", {30'h0, grant}, 0);
    rst = 1'b1;
    cyc();

    // Reset asserted while a byte is held in SEND
    push(2'b01, 9'h101, 9'h000);
    wait_valid("rst_reach_send");
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_mid_rd_en", {30'h0, src_rd_en}, 0);
    chk("rst_mid_tx_data", {24'h0, tx_data}, 0);
    chk("rst_mid_tx_last", {31'h0, tx_last}, 0);
    chk("rst_mid_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_mid_grant", {30'h0, grant}, 0);
    chk("rst_mid_busy", {31'h0, busy}, 0);
    chk("rst_mid_terr", {31'h0, timeout_err}, 0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_busy", {31'h0, busy}, 0);
    chk("post_rst_grant", {30'h0, grant}, 0);

    // Contention: src0 wins from rr_ptr=0, then src1
    tx_ready = 1'b1;
    expect_b(2'b01, 9'h011);
    expect_b(2'b01, 9'h122);
    expect_b(2'b10, 9'h033);
    expect_b(2'b10, 9'h144);
    push(2'b11, 9'h011, 9'h033);
    push(2'b11, 9'h122, 9'h144);
    drain("drain_contention");

    // Timeout: src0 frame never finishes, src1 served afterwards
    chk("tout_none_before", tcount, 0);
    expect_b(2'b01, 9'h0AA);
    expect_b(2'b10, 9'h1BB);
    push(2'b11, 9'h0AA, 9'h1BB);
    drain("drain_timeout");
    chk("tout_pulse_once", tcount, 1);
    chk("tout_gap", tgap, 9);

    // Single frame and first-byte latency
    expect_b(2'b01, 9'h055);
    expect_b(2'b01, 9'h0C5);
    expect_b(2'b01, 9'h104);
    push(2'b01, 9'h055, 9'h000);
    n = 0;
    push(2'b01, 9'h0C5, 9'h000);
    n++;
    push(2'b01, 9'h104, 9'h000);
    n++;
    while (!tx_valid && n < 30) begin
      cyc();
      n++;
    end
    chk("first_valid_latency", n, 3);
    drain("drain_single");

    // Backpressure: outputs must hold while tx_ready is low
    tx_ready = 1'b0;
    expect_b(2'b01, 9'h077);
    expect_b(2'b01, 9'h188);
    push(2'b01, 9'h077, 9'h000);
    push(2'b01, 9'h188, 9'h000);
    wait_valid("bp_valid");
    hd = tx_data;
    hl = tx_last;
    hg = grant;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tx_data !== hd || tx_last !== hl || grant !== hg ||
          src_rd_en !== 2'b00 || tx_valid !== 1'b1)
        bad++;
    end
    chk("bp_hold", bad, 0);
    chk("bp_data", {24'h0, tx_data}, 32'h77);
    tx_ready = 1'b1;
    drain("drain_bp");

    // Fairness: src1 frame slots in right after src0's current frame
    expect_b(2'b01, 9'h1A0);
    expect_b(2'b10, 9'h1EE);
    expect_b(2'b01, 9'h1A1);
    expect_b(2'b01, 9'h1A2);
    expect_b(2'b01, 9'h1A3);
    expect_b(2'b01, 9'h1A4);
    expect_b(2'b01, 9'h1A5);
    push(2'b01, 9'h1A0, 9'h000);
    push(2'b11, 9'h1A1, 9'h1EE);
    push(2'b01, 9'h1A2, 9'h000);
    push(2'b01, 9'h1A3, 9'h000);
    push(2'b01, 9'h1A4, 9'h000);
    push(2'b01, 9'h1A5, 9'h000);
    drain("drain_fair");
    chk("tout_total", tcount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
